// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer:
// opcodes, state codes, ALU-op codes, mux selects and the control vector.
package mc_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_RWB    = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_IEXEC  = 4'd10,
    ST_IWB    = 4'd11,
    ST_HALT   = 4'd15
  } state_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       halted;
  } ctrl_t;

  function automatic logic [2:0] iexec_alu_op(input logic [5:0] op);
    case (op)
      OP_SLTI: return ALU_SLT;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Moore decode of the registered state into the datapath control vector.
// mem_ready only gates the IR/PC load in FETCH; opcode only picks the I-type ALU op.
module mc_out_decode
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ST_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      ST_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = iexec_alu_op(opcode);
      end
      ST_IWB: begin
        ctrl.reg_write = 1'b1;
      end
      ST_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS sequencer: state register, next-state logic and retired-instruction
// counter. mem_ready: the request held this cycle completes; requests stay up until seen.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic [3:0]       state_o,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  state_t state;
  state_t next_state;
  logic   retire;
  ctrl_t  ctrl;
  ctrl_t  ctrl_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FETCH;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    case (state)
      ST_FETCH:  if (mem_ready) next_state = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                       next_state = ST_MEMADR;
          OP_R:                               next_state = ST_EXEC;
          OP_BEQ:                             next_state = ST_BRANCH;
          OP_J:                               next_state = ST_JUMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  next_state = ST_IEXEC;
          default:                            next_state = ST_HALT;
        endcase
      end
      ST_MEMADR: begin
        if (opcode == OP_LW)      next_state = ST_MEMRD;
        else if (opcode == OP_SW) next_state = ST_MEMWR;
        else                      next_state = ST_HALT;
      end
      ST_MEMRD:  if (mem_ready) next_state = ST_MEMWB;
      ST_MEMWR: begin
        if (mem_ready) begin
          next_state = ST_FETCH;
          retire     = 1'b1;
        end
      end
      ST_EXEC:   next_state = ST_RWB;
      ST_IEXEC:  next_state = ST_IWB;
      ST_MEMWB, ST_RWB, ST_BRANCH, ST_JUMP, ST_IWB: begin
        next_state = ST_FETCH;
        retire     = 1'b1;
      end
      ST_HALT:   next_state = ST_HALT;
      default:   next_state = ST_HALT;
    endcase
  end

  mc_out_decode u_out_decode (
    .state     (state),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Reset silences the datapath immediately, even before the state register settles.
  assign ctrl_eff    = rst ? '0 : ctrl;
  assign pc_en       = ctrl_eff.pc_write | (ctrl_eff.pc_write_cond & zero);
  assign iord        = ctrl_eff.iord;
  assign mem_read    = ctrl_eff.mem_read;
  assign mem_write   = ctrl_eff.mem_write;
  assign ir_write    = ctrl_eff.ir_write;
  assign mem_to_reg  = ctrl_eff.mem_to_reg;
  assign reg_write   = ctrl_eff.reg_write;
  assign reg_dst     = ctrl_eff.reg_dst;
  assign alu_src_a   = ctrl_eff.alu_src_a;
  assign alu_src_b   = ctrl_eff.alu_src_b;
  assign alu_op      = ctrl_eff.alu_op;
  assign pc_src      = ctrl_eff.pc_src;
  assign halted      = ctrl_eff.halted;
  assign state_o     = state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: table-driven instruction vectors plus hand-written wait,
// reset, halt and counter-wrap sequences; a 4-bit-counter instance runs alongside.
module tb_mc_ctrl_fsm;

  localparam int W = 21;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic        pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write;
  logic        reg_dst, alu_src_a, halted;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_op;
  logic [3:0]  state_o;
  logic [15:0] instr_count;

  logic        q_pc_en, q_iord, q_mem_read, q_mem_write, q_ir_write, q_mem_to_reg;
  logic        q_reg_write, q_reg_dst, q_alu_src_a, q_halted;
  logic [1:0]  q_alu_src_b, q_pc_src;
  logic [2:0]  q_alu_op;
  logic [3:0]  q_state_o;
  logic [3:0]  q_instr_count;

  mc_ctrl_fsm #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .reg_dst(reg_dst), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .state_o(state_o), .halted(halted),
    .instr_count(instr_count)
  );

  mc_ctrl_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(q_pc_en), .iord(q_iord), .mem_read(q_mem_read), .mem_write(q_mem_write),
    .ir_write(q_ir_write), .mem_to_reg(q_mem_to_reg), .reg_write(q_reg_write),
    .reg_dst(q_reg_dst), .alu_src_a(q_alu_src_a), .alu_src_b(q_alu_src_b),
    .alu_op(q_alu_op), .pc_src(q_pc_src), .state_o(q_state_o), .halted(q_halted),
    .instr_count(q_instr_count)
  );

  logic [W-1:0] obs;
  assign obs = {state_o, pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg,
                reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_src, halted};

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] exp_count = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected outputs straight from the state table.
  function automatic logic [W-1:0] exp_word(input logic [3:0] st, input logic [5:0] op,
                                            input logic z, input logic mr, input logic r);
    logic pe, io, mrd, mwr, irw, m2r, rw, rd, sa, hl;
    logic [1:0] sb, ps;
    logic [2:0] ao;
    {pe, io, mrd, mwr, irw, m2r, rw, rd, sa, hl} = '0;
    sb = 2'b00; ps = 2'b00; ao = 3'b000;
    if (!r) begin
      case (st)
        4'd0:  begin mrd = 1; sb = 2'b01; irw = mr; pe = mr; end
        4'd1:  sb = 2'b11;
        4'd2:  begin sa = 1; sb = 2'b10; end
        4'd3:  begin mrd = 1; io = 1; end
        4'd4:  begin rw = 1; m2r = 1; end
        4'd5:  begin mwr = 1; io = 1; end
        4'd6:  begin sa = 1; ao = 3'b010; end
        4'd7:  begin rw = 1; rd = 1; end
        4'd8:  begin sa = 1; ao = 3'b001; pe = z; ps = 2'b01; end
        4'd9:  begin pe = 1; ps = 2'b10; end
        4'd10: begin
          sa = 1; sb = 2'b10;
          case (op)
            6'b001010: ao = 3'b011;
            6'b001100: ao = 3'b100;
            6'b001101: ao = 3'b101;
            default:   ao = 3'b000;
          endcase
        end
        4'd11: rw = 1;
        4'd15: hl = 1;
        default: ;
      endcase
    end
    return {st, pe, io, mrd, mwr, irw, m2r, rw, rd, sa, sb, ao, ps, hl};
  endfunction

  // driver: called #1 after a rising edge; compares at the falling edge
  task automatic cyc(input logic [3:0] st, input logic [5:0] op, input logic z,
                     input logic mr, input logic r, input string name);
    logic [W-1:0] e;
    opcode = op; zero = z; mem_ready = mr; rst = r;
    exp_q.push_back(exp_word(st, op, z, mr, r));
    @(negedge clk);
    e = exp_q.pop_front();
    check(name, 32'(obs), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic check_count(input string name);
    check({name, "_cnt"},  32'(instr_count),   32'(exp_count));
    check({name, "_cnt4"}, 32'(q_instr_count), 32'(exp_count[3:0]));
  endtask

  typedef struct {
    string      name;
    logic [5:0] op;
    logic       z;
    int         len;
    logic [3:0] seq [5];
  } vec_t;

  vec_t vecs[10];
  int   nvec = 0;

  task automatic add_vec(input string n, input logic [5:0] op, input logic z, input int len,
                         input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                         input logic [3:0] s3, input logic [3:0] s4);
    vecs[nvec].name = n;
    vecs[nvec].op   = op;
    vecs[nvec].z    = z;
    vecs[nvec].len  = len;
    vecs[nvec].seq[0] = s0; vecs[nvec].seq[1] = s1; vecs[nvec].seq[2] = s2;
    vecs[nvec].seq[3] = s3; vecs[nvec].seq[4] = s4;
    nvec++;
  endtask

  task automatic run_vec(input int i);
    for (int k = 0; k < vecs[i].len; k++)
      cyc(vecs[i].seq[k], vecs[i].op, vecs[i].z, 1'b1, 1'b0, vecs[i].name);
    exp_count++;
    check_count(vecs[i].name);
  endtask

  task automatic do_reset();
    cyc(state_o, 6'b000000, 1'b0, 1'b0, 1'b1, "reset_cycle");
    exp_count = '0;
    check_count("after_reset");
  endtask

  initial begin
    add_vec("lw",     6'b100011, 1'b0, 5, 0, 1, 2, 3, 4);
    add_vec("sw",     6'b101011, 1'b0, 4, 0, 1, 2, 5, 0);
    add_vec("rtype",  6'b000000, 1'b1, 4, 0, 1, 6, 7, 0);
    add_vec("beq_z1", 6'b000100, 1'b1, 3, 0, 1, 8, 0, 0);
    add_vec("beq_z0", 6'b000100, 1'b0, 3, 0, 1, 8, 0, 0);
    add_vec("j",      6'b000010, 1'b1, 3, 0, 1, 9, 0, 0);
    add_vec("addi",   6'b001000, 1'b0, 4, 0, 1, 10, 11, 0);
    add_vec("slti",   6'b001010, 1'b0, 4, 0, 1, 10, 11, 0);
    add_vec("andi",   6'b001100, 1'b1, 4, 0, 1, 10, 11, 0);
    add_vec("ori",    6'b001101, 1'b0, 4, 0, 1, 10, 11, 0);

    rst = 1'b1;
    @(posedge clk); #1;
    cyc(4'd0, 6'b000000, 1'b1, 1'b1, 1'b1, "reset_outputs");
    exp_count = '0;
    check_count("reset");

    for (int i = 0; i < nvec; i++) run_vec(i);

    // FETCH stalled three cycles, then an R-type completes
    for (int k = 0; k < 3; k++) cyc(4'd0, 6'b000000, 1'b0, 1'b0, 1'b0, "fetch_wait");
    cyc(4'd0, 6'b000000, 1'b0, 1'b1, 1'b0, "fetch_go");
    cyc(4'd1, 6'b000000, 1'b0, 1'b1, 1'b0, "fw_decode");
    cyc(4'd6, 6'b000000, 1'b0, 1'b1, 1'b0, "fw_exec");
    cyc(4'd7, 6'b000000, 1'b0, 1'b1, 1'b0, "fw_rwb");
    exp_count++;
    check_count("fetch_wait");

    // sw waiting two cycles in MEMWR
    cyc(4'd0, 6'b101011, 1'b0, 1'b1, 1'b0, "sww_fetch");
    cyc(4'd1, 6'b101011, 1'b0, 1'b1, 1'b0, "sww_decode");
    cyc(4'd2, 6'b101011, 1'b0, 1'b1, 1'b0, "sww_memadr");
    cyc(4'd5, 6'b101011, 1'b0, 1'b0, 1'b0, "sww_wait");
    cyc(4'd5, 6'b101011, 1'b1, 1'b0, 1'b0, "sww_wait");
    cyc(4'd5, 6'b101011, 1'b0, 1'b1, 1'b0, "sww_done");
    exp_count++;
    check_count("sw_wait");

    // lw waiting in MEMRD
    cyc(4'd0, 6'b100011, 1'b0, 1'b1, 1'b0, "lww_fetch");
    cyc(4'd1, 6'b100011, 1'b0, 1'b1, 1'b0, "lww_decode");
    cyc(4'd2, 6'b100011, 1'b0, 1'b1, 1'b0, "lww_memadr");
    cyc(4'd3, 6'b100011, 1'b0, 1'b0, 1'b0, "lww_wait");
    cyc(4'd3, 6'b100011, 1'b0, 1'b0, 1'b0, "lww_wait");
    cyc(4'd3, 6'b100011, 1'b0, 1'b1, 1'b0, "lww_done");
    cyc(4'd4, 6'b100011, 1'b0, 1'b1, 1'b0, "lww_memwb");
    exp_count++;
    check_count("lw_wait");

    // reset pulse while lw waits in MEMRD
    cyc(4'd0, 6'b100011, 1'b0, 1'b1, 1'b0, "rm_fetch");
    cyc(4'd1, 6'b100011, 1'b0, 1'b1, 1'b0, "rm_decode");
    cyc(4'd2, 6'b100011, 1'b0, 1'b1, 1'b0, "rm_memadr");
    cyc(4'd3, 6'b100011, 1'b0, 1'b0, 1'b0, "rm_wait");
    cyc(4'd3, 6'b100011, 1'b0, 1'b0, 1'b1, "rm_rst_outputs");
    exp_count = '0;
    check_count("rst_mid");
    run_vec(0);

    // illegal opcode halts until reset
    cyc(4'd0, 6'b111111, 1'b0, 1'b1, 1'b0, "ill_fetch");
    cyc(4'd1, 6'b111111, 1'b0, 1'b1, 1'b0, "ill_decode");
    for (int k = 0; k < 100; k++)
      cyc(4'd15, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'b0, "halt_hold");
    check_count("halt");
    cyc(4'd15, 6'b000000, 1'b1, 1'b1, 1'b1, "halt_rst");
    exp_count = '0;
    run_vec(2);

    // random instruction mix
    for (int k = 0; k < 20; k++) run_vec(int'($urandom_range(0, nvec - 1)));

    // 16 back-to-back R-types: the 4-bit counter wraps 15 -> 0
    do_reset();
    for (int k = 0; k < 16; k++) begin
      run_vec(2);
      if (k == 14) check("wrap_15", 32'(q_instr_count), 32'd15);
      if (k == 15) check("wrap_0",  32'(q_instr_count), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
